// File: rtl/fpu_pkg.sv
// Shared definitions for the FP sign-manipulation / classification group:
// op codes, fclass bit positions and the IEEE-754 single field helpers.
package fpu_pkg;

  typedef enum logic [2:0] {
    OP_SGNJ  = 3'd0,
    OP_SGNJN = 3'd1,
    OP_SGNJX = 3'd2,
    OP_CLASS = 3'd3,
    OP_MV    = 3'd4
  } op_t;

  localparam int unsigned FCLASS_NEG_INF  = 0;
  localparam int unsigned FCLASS_NEG_NORM = 1;
  localparam int unsigned FCLASS_NEG_SUB  = 2;
  localparam int unsigned FCLASS_NEG_ZERO = 3;
  localparam int unsigned FCLASS_POS_ZERO = 4;
  localparam int unsigned FCLASS_POS_SUB  = 5;
  localparam int unsigned FCLASS_POS_NORM = 6;
  localparam int unsigned FCLASS_POS_INF  = 7;
  localparam int unsigned FCLASS_SNAN     = 8;
  localparam int unsigned FCLASS_QNAN     = 9;

  localparam logic [7:0] EXP_MAX = 8'hFF;

  // One-hot class of a single-precision word; NaNs carry no sign class.
  function automatic logic [9:0] fclass(input logic [31:0] x);
    logic        sign;
    logic [7:0]  expo;
    logic [22:0] mant;
    logic [9:0]  cls;
    sign = x[31];
    expo = x[30:23];
    mant = x[22:0];
    cls  = '0;
    if (expo == EXP_MAX) begin
      if (mant == '0) begin
        if (sign) cls[FCLASS_NEG_INF] = 1'b1;
        else      cls[FCLASS_POS_INF] = 1'b1;
      end else if (mant[22]) begin
        cls[FCLASS_QNAN] = 1'b1;
      end else begin
        cls[FCLASS_SNAN] = 1'b1;
      end
    end else if (expo == '0) begin
      if (mant == '0) begin
        if (sign) cls[FCLASS_NEG_ZERO] = 1'b1;
        else      cls[FCLASS_POS_ZERO] = 1'b1;
      end else begin
        if (sign) cls[FCLASS_NEG_SUB] = 1'b1;
        else      cls[FCLASS_POS_SUB] = 1'b1;
      end
    end else begin
      if (sign) cls[FCLASS_NEG_NORM] = 1'b1;
      else      cls[FCLASS_POS_NORM] = 1'b1;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fpu_sign_unit_if.sv
// Request/response handshake bundle between FP issue, the sign unit and
// the FP writeback arbiter.
interface fpu_sign_unit_if #(
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      req_x1;
  logic [31:0]      req_x2;
  logic             resp_valid;
  logic             resp_ready;
  logic [TAG_W-1:0] resp_tag;
  logic [31:0]      resp_data;
  logic             resp_err;

  modport master (
    output req_valid, req_op, req_tag, req_x1, req_x2, resp_ready,
    input  req_ready, resp_valid, resp_tag, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_tag, req_x1, req_x2, resp_ready,
    output req_ready, resp_valid, resp_tag, resp_data, resp_err
  );
endinterface

// File: rtl/fsgn_core.sv
// Combinational sign-injection / fclass / move datapath. Bit-exact: only
// bit 31 drives sign decisions, payloads pass through untouched.
module fsgn_core
  import fpu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] x1_i,
  input  logic [31:0] x2_i,
  output logic [31:0] data_o,
  output logic        err_o
);

  // Only the sign of x2 participates in any operation.
  logic unused_x2_mag;
  assign unused_x2_mag = ^x2_i[30:0];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    data_o = '0;
    err_o  = 1'b0;
    case (op_i)
      OP_SGNJ:  data_o = {x2_i[31], x1_i[30:0]};
      OP_SGNJN: data_o = {~x2_i[31], x1_i[30:0]};
      OP_SGNJX: data_o = {x1_i[31] ^ x2_i[31], x1_i[30:0]};
      OP_CLASS: data_o = {22'b0, fclass(x1_i)};
      OP_MV:    data_o = x1_i;
      default:  err_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/fpu_sign_unit.sv
// Two-stage valid/ready pipeline around fsgn_core: S1 holds the request,
// S2 holds the result and drives the response bus straight from flops.
module fpu_sign_unit #(
  parameter int TAG_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  fpu_sign_unit_if.slave bus
);

  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [31:0]      s1_x1_q;
  logic [31:0]      s1_x2_q;

  logic             s2_valid_q, s2_valid_d;
  logic [TAG_W-1:0] s2_tag_q;
  logic [31:0]      s2_data_q;
  logic             s2_err_q;

  logic             req_ready;
  logic             s1_load;
  logic             s2_load;
  logic [31:0]      core_data;
  logic             core_err;

  // resp_ready reaches req_ready combinationally: a retiring S2 frees room.
  assign req_ready  = !s1_valid_q || !s2_valid_q || bus.resp_ready;
  assign s1_load    = bus.req_valid && req_ready;
  assign s2_load    = s1_valid_q && (!s2_valid_q || bus.resp_ready);

  assign s1_valid_d = s1_load || (s1_valid_q && !s2_load);
  assign s2_valid_d = s2_load || (s2_valid_q && !bus.resp_ready);

  fsgn_core u_core (
    .op_i   (s1_op_q),
    .x1_i   (s1_x1_q),
    .x2_i   (s1_x2_q),
    .data_o (core_data),
    .err_o  (core_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_tag_q   <= '0;
      s2_data_q  <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        s2_tag_q  <= s1_tag_q;
        s2_data_q <= core_data;
        s2_err_q  <= core_err;
      end
    end
  end

  // NOTE: S1 payload is never observed without s1_valid_q, so it carries
  // no reset; only the valid bit and the visible S2 word are cleared.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_op_q  <= bus.req_op;
      s1_tag_q <= bus.req_tag;
      s1_x1_q  <= bus.req_x1;
      s1_x2_q  <= bus.req_x2;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = s2_valid_q;
  assign bus.resp_tag   = s2_tag_q;
  assign bus.resp_data  = s2_data_q;
  assign bus.resp_err   = s2_err_q;

endmodule

// File: tb/tb_fpu_sign_unit.sv
// Self-checking bench for fpu_sign_unit: directed scenarios plus a random
// soak against a field-level IEEE-754 reference model and scoreboard.
module tb_fpu_sign_unit;
  import fpu_pkg::*;

  localparam int TAG_W    = 5;
  localparam int N_OPS    = 20000;
  localparam int BUDGET   = 60000;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic             err;
  } resp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  fpu_sign_unit_if #(.TAG_W(TAG_W)) bus ();
  fpu_sign_unit #(.TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Reference classification from the IEEE-754 field definitions.
  function automatic logic [31:0] ref_class(input logic [31:0] x);
    bit          neg;
    int unsigned e;
    int unsigned m;
    int          k;
    neg = x[31];
    e   = int'(x[30:23]);
    m   = int'(x[22:0]);
    if (e == 255 && m == 0)      k = neg ? 0 : 7;
    else if (e == 255)           k = (m >= 32'h40_0000) ? 9 : 8;
    else if (e == 0 && m == 0)   k = neg ? 3 : 4;
    else if (e == 0)             k = neg ? 2 : 5;
    else                         k = neg ? 1 : 6;
    return 32'd1 << k;
  endfunction

  function automatic resp_t ref_op(input logic [2:0] op, input logic [TAG_W-1:0] tag,
                                   input logic [31:0] x1, input logic [31:0] x2);
    resp_t r;
    bit    neg1, neg2;
    neg1   = x1[31];
    neg2   = x2[31];
    r.tag  = tag;
    r.err  = 1'b0;
    r.data = x1;
    case (int'(op))
      0:       r.data[31] = neg2;
      1:       r.data[31] = !neg2;
      2:       r.data[31] = (neg1 != neg2);
      3:       r.data     = ref_class(x1);
      4:       r.data     = x1;
      default: begin r.data = '0; r.err = 1'b1; end
    endcase
    return r;
  endfunction

  // Biased operand source: zeros, infinities, NaNs and subnormals are frequent.
  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    logic [22:0] pay;
    v   = $urandom;
    pay = 23'($urandom);
    case ($urandom_range(0, 7))
      0: v = {v[31], 31'b0};
      1: v = {v[31], 8'hFF, 23'b0};
      2: v = {v[31], 8'hFF, 1'b1, pay[21:0]};
      3: v = {v[31], 8'hFF, 1'b0, pay[21:1], 1'b1};
      4: v = {v[31], 8'h00, pay[22:1], 1'b1};
      default: ;
    endcase
    return v;
  endfunction

  // Drive one cycle at the falling edge, then settle for sampling.
  task automatic drive(input logic v, input logic [2:0] op, input logic [TAG_W-1:0] tag,
                       input logic [31:0] x1, input logic [31:0] x2, input logic rr);
    @(negedge clk);
    bus.req_valid  = v;
    bus.req_op     = op;
    bus.req_tag    = tag;
    bus.req_x1     = x1;
    bus.req_x2     = x2;
    bus.resp_ready = rr;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 3'd0, '0, '0, '0, 1'b0);
    drive(1'b0, 3'd0, '0, '0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_resp_valid got=%b want=0", bus.resp_valid);
    end
    vectors++;
    if (bus.resp_data !== 32'h0) begin
      miscompares++; $display("FAIL reset_resp_data got=%h want=00000000", bus.resp_data);
    end
    vectors++;
    if (bus.resp_tag !== '0) begin
      miscompares++; $display("FAIL reset_resp_tag got=%h want=0", bus.resp_tag);
    end
    vectors++;
    if (bus.resp_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_resp_err got=%b want=0", bus.resp_err);
    end
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_req_ready got=%b want=1", bus.req_ready);
    end
  endtask

  task automatic test_sign_inject();
    vec_t v [3];
    logic [TAG_W+33:0] got, want;
    v[0] = '{OP_SGNJN, 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000};
    v[1] = '{OP_SGNJ,  32'h3F80_0000, 32'h8000_0000, 32'hBF80_0000};
    v[2] = '{OP_SGNJX, 32'hBF80_0000, 32'hC000_0000, 32'h3F80_0000};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, v[i].op, TAG_W'(i + 1), v[i].x1, v[i].x2, 1'b1);
      vectors++;
      if (bus.req_ready !== 1'b1) begin
        miscompares++; $display("FAIL sgn%0d_req_ready got=%b want=1", i, bus.req_ready);
      end
      drive(1'b0, 3'd0, '0, '0, '0, 1'b1);
      vectors++;
      if (bus.resp_valid !== 1'b0) begin
        miscompares++; $display("FAIL sgn%0d_early_valid got=%b want=0", i, bus.resp_valid);
      end
      drive(1'b0, 3'd0, '0, '0, '0, 1'b1);
      got  = {bus.resp_valid, bus.resp_tag, bus.resp_data, bus.resp_err};
      want = {1'b1, TAG_W'(i + 1), v[i].exp, 1'b0};
      vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL sgn%0d_result {v,tag,data,err} got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_fclass();
    logic [31:0]       x [10];
    logic [31:0]       e [10];
    logic [TAG_W+33:0] got, want;
    x = '{32'hFF80_0000, 32'h8000_0000, 32'h0000_0001, 32'h7F80_0000, 32'h7F80_0001,
          32'h7FC0_0000, 32'hBF80_0000, 32'h8000_0001, 32'h0000_0000, 32'h3F80_0000};
    e = '{32'h001, 32'h008, 32'h020, 32'h080, 32'h100,
          32'h200, 32'h002, 32'h004, 32'h010, 32'h040};
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, OP_CLASS, TAG_W'(i), x[i], $urandom, 1'b1);
      drive(1'b0, 3'd0, '0, '0, '0, 1'b1);
      drive(1'b0, 3'd0, '0, '0, '0, 1'b1);
      got  = {bus.resp_valid, bus.resp_tag, bus.resp_data, bus.resp_err};
      want = {1'b1, TAG_W'(i), e[i], 1'b0};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL fclass_%h {v,tag,data,err} got=%h want=%h", x[i], got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0]       d [4];
    logic [TAG_W+32:0] got, want;
    for (int i = 1; i < 4; i++) d[i] = 32'hA000_0000 | 32'(i * 17);
    drive(1'b1, OP_MV, 5'd1, d[1], '0, 1'b0);
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++; $display("FAIL b2b_accept1 req_ready got=%b want=1", bus.req_ready);
    end
    drive(1'b1, OP_MV, 5'd2, d[2], '0, 1'b0);
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++; $display("FAIL b2b_accept2 req_ready got=%b want=1", bus.req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, OP_MV, 5'd3, d[3], '0, 1'b0);
      vectors++;
      if (bus.req_ready !== 1'b0) begin
        miscompares++; $display("FAIL b2b_full%0d req_ready got=%b want=0", c, bus.req_ready);
      end
      got  = {bus.resp_valid, bus.resp_tag, bus.resp_data};
      want = {1'b1, 5'd1, d[1]};
      vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL b2b_stall%0d {v,tag,data} got=%h want=%h", c, got, want);
      end
    end
    drive(1'b1, OP_MV, 5'd3, d[3], '0, 1'b1);
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++; $display("FAIL b2b_accept3 req_ready got=%b want=1", bus.req_ready);
    end
    for (int t = 1; t < 4; t++) begin
      if (t > 1) drive(1'b0, 3'd0, '0, '0, '0, 1'b1);
      got  = {bus.resp_valid, bus.resp_tag, bus.resp_data};
      want = {1'b1, TAG_W'(t), d[t]};
      vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL b2b_drain_tag%0d {v,tag,data} got=%h want=%h", t, got, want);
      end
    end
    drive(1'b0, 3'd0, '0, '0, '0, 1'b1);
    vectors++;
    if (bus.resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL b2b_repeat resp_valid got=%b want=0", bus.resp_valid);
    end
  endtask

  task automatic test_illegal_op();
    logic [TAG_W+33:0] got, want;
    drive(1'b1, 3'd6, 5'd7, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1);
    drive(1'b1, OP_MV, 5'd8, 32'h1234_5678, 32'h8000_0000, 1'b1);
    drive(1'b0, 3'd0, '0, '0, '0, 1'b1);
    got  = {bus.resp_valid, bus.resp_tag, bus.resp_data, bus.resp_err};
    want = {1'b1, 5'd7, 32'h0, 1'b1};
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL illegal_op {v,tag,data,err} got=%h want=%h", got, want);
    end
    drive(1'b0, 3'd0, '0, '0, '0, 1'b1);
    want = {1'b1, 5'd8, 32'h1234_5678, 1'b0};
    got  = {bus.resp_valid, bus.resp_tag, bus.resp_data, bus.resp_err};
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL after_illegal_mv {v,tag,data,err} got=%h want=%h", got, want);
    end
    drive(1'b0, 3'd0, '0, '0, '0, 1'b1);
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, OP_MV, 5'd9,  32'h1111_1111, '0, 1'b0);
    drive(1'b1, OP_MV, 5'd10, 32'h2222_2222, '0, 1'b0);
    drive(1'b0, 3'd0, '0, '0, '0, 1'b0);
    vectors++;
    if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_prefill {resp_valid,req_ready} got=%b%b want=10", bus.resp_valid, bus.req_ready);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL midrst_async resp_valid got=%b want=0", bus.resp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 3'd0, '0, '0, '0, 1'b1);
      vectors++;
      if (bus.resp_valid !== 1'b0) begin
        miscompares++; $display("FAIL midrst_stale%0d resp_valid got=%b want=0", c, bus.resp_valid);
      end
    end
  endtask

  task automatic test_random_soak();
    resp_t      sb [$];
    resp_t      cur, held, exp_r;
    logic       held_valid;
    logic       v, rr;
    logic [2:0] op;
    logic [TAG_W-1:0] tag;
    logic [31:0] x1, x2;
    int         issued, cycles;
    issued     = 0;
    cycles     = 0;
    held_valid = 1'b0;
    held       = '0;
    while ((issued < N_OPS || sb.size() != 0) && cycles < BUDGET) begin
      v   = (issued < N_OPS) && ($urandom_range(0, 3) != 0);
      rr  = ($urandom_range(0, 3) != 0);
      op  = 3'($urandom_range(0, 7));
      tag = TAG_W'($urandom);
      x1  = rand_operand();
      x2  = rand_operand();
      drive(v, op, tag, x1, x2, rr);
      cycles++;
      cur = '{tag: bus.resp_tag, data: bus.resp_data, err: bus.resp_err};
      if (held_valid) begin
        vectors++;
        if (bus.resp_valid !== 1'b1 || cur !== held) begin
          miscompares++;
          $display("FAIL soak_stall_stable cyc=%0d {v,resp} got=%b_%h want=1_%h",
                   cycles, bus.resp_valid, cur, held);
        end
      end
      held_valid = bus.resp_valid && !rr;
      held       = cur;
      if (bus.resp_valid && rr) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL soak_spurious cyc=%0d got=%h want=no response", cycles, cur);
        end else begin
          exp_r = sb.pop_front();
          if (cur !== exp_r) begin
            miscompares++;
            $display("FAIL soak_result cyc=%0d {tag,data,err} got=%h want=%h", cycles, cur, exp_r);
          end
        end
      end
      if (v && bus.req_ready) begin
        sb.push_back(ref_op(op, tag, x1, x2));
        issued++;
      end
    end
    vectors++;
    if (issued != N_OPS || sb.size() != 0) begin
      miscompares++;
      $display("FAIL soak_timeout issued=%0d pending=%0d want issued=%0d pending=0",
               issued, sb.size(), N_OPS);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_tag    = '0;
    bus.req_x1     = '0;
    bus.req_x2     = '0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_sign_inject();
    test_fclass();
    test_back_to_back();
    test_illegal_op();
    test_reset_midflight();
    test_random_soak();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
